edge_pulse_gen: RTL and testbench
=================================

// Module: edge_pulse_gen
// PURPOSE
//  Multi-channel level-to-pulse converter, successor to the single-bit rising-edge detector.
//  Per channel: optional input synchroniser, selectable edge mode (rise/fall/both),
//  programmable pulse width with retrigger, and a sticky event flag with clear.
//  Sits between async/slow control levels (buttons, status lines) and single-cycle-driven FSMs.
// PARAMETERS
//  N_CH         8   number of independent channels (>=1)
//  SYNC_STAGES  2   synchroniser flops per channel; 0 = bypass (input already in clk domain)
//  PULSE_W      1   output pulse width in clk cycles (>=1)
//  DEBOUNCE_CYC 4   stable cycles required before a level change is accepted (macro only, >=1)
// PORTS
//  clk          in   1         clock, all logic on posedge
//  reset        in   1         synchronous, active-high
//  level_in     in   N_CH      raw level inputs
//  mode         in   2*N_CH    per-channel mode, ch i = mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr          in   N_CH      per-channel sticky-flag clear, sampled each cycle
//  pulse_out    out  N_CH      registered pulse outputs
//  event_flag   out  N_CH      sticky: set on any detected edge, held until clr
//  any_pulse    out  1         registered OR of pulse_out next-state (high same cycles as |pulse_out)
// BEHAVIOUR
//  Reset: all sync flops, prev-level regs, width counters, pulse_out, event_flag, any_pulse = 0.
//   Prev-level resets to 0: a channel held high through reset yields a rising edge after release.
//  Path per channel: level_in -> SYNC_STAGES flops -> lvl (filtered level) -> prev reg.
//   rise = lvl & ~prev; fall = ~lvl & prev; det = (rise & mode[0]) | (fall & mode[1]).
//  Latency: level change set up before posedge k -> pulse_out high after posedge k+SYNC_STAGES
//   (SYNC_STAGES=0: after posedge k, identical to legacy single-bit block).
//  Width: det loads down-counter with PULSE_W; pulse_out = 1 while counter != 0, so exactly
//   PULSE_W consecutive high cycles per isolated edge. Counter width = $clog2(PULSE_W+1).
//  Retrigger: det while pulse active reloads counter to PULSE_W; pulse stays high continuously,
//   ends PULSE_W cycles after last det. No gaps, no queued pulses.
//  PULSE_W=1 with edges every cycle (mode 11, toggling input): pulse_out held high continuously.
//  Mode: sampled each cycle with det; change to 00 mid-pulse does NOT truncate an active pulse.
//   Edges occurring while mode=00 are lost (prev still tracks lvl, no deferred detection).
//  Sticky: event_flag[i] <= (event_flag[i] & ~clr[i]) | det[i]; simultaneous det and clr -> set wins.
//  Channels fully independent; no cross-channel arbitration.
//  Reset asserted mid-pulse: pulse_out drops to 0 on the next posedge; in-flight sync data discarded.
// CONFIGURATION
//  EDGE_PULSE_DEBOUNCE_EN defined:
//   per-channel counter, $clog2(DEBOUNCE_CYC+1) bits; lvl updates to synced value only after
//   synced != lvl for DEBOUNCE_CYC consecutive cycles; any return to lvl resets counter to 0.
//   lvl resets to 0. Adds DEBOUNCE_CYC cycles latency: pulse after posedge k+SYNC_STAGES+DEBOUNCE_CYC.
//   Glitches shorter than DEBOUNCE_CYC cycles produce no pulse and no event_flag.
//  Not defined: lvl = synced value directly, no debounce logic, DEBOUNCE_CYC ignored.
// TESTING
//  Defaults, macro off. Ch0 mode=01, level_in[0] 0->1 before edge k -> pulse_out[0]=1 exactly
//   one cycle after posedge k+2, any_pulse matches, event_flag[0]=1 held; 1->0 -> no pulse.
//  PULSE_W=3, ch1 mode=11, rise then fall 2 cycles apart -> pulse_out[1] high 5 cycles continuously.
//  Ch2 mode=10 then switched to 00 one cycle after pulse start (PULSE_W=3) -> pulse runs full 3 cycles;
//   subsequent falls while 00 -> no pulse, no flag.
//  event_flag[3]=1, clr[3]=1 same cycle as new det on ch3 -> flag stays 1; clr alone next cycle -> 0.
//  level_in=8'hFF held through reset, reset released -> all ch with mode 01/11 pulse once after 3 edges.
//  Macro on, DEBOUNCE_CYC=4: 3-cycle high glitch -> no pulse; 6-cycle high -> one pulse at k+6 edge.

Source files
------------

// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: multi-channel level-to-pulse converter.
// Each channel has an optional synchroniser and a rise/fall/both edge select.
// Each channel drives a retriggerable pulse of PULSE_W cycles and a sticky event flag.
// Optional feature: define EDGE_PULSE_DEBOUNCE_EN to insert a per-channel debounce filter
// of DEBOUNCE_CYC stable cycles between the synchroniser and the edge detector.
module edge_pulse_gen #(
   parameter int N_CH         = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int PULSE_W      = 1,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   level_in,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   pulse_out,
   output logic [N_CH-1:0]   event_flag,
   output logic              any_pulse
);

   localparam int CW = $clog2(PULSE_W + 1);

   logic [N_CH-1:0] w_sync;
   logic [N_CH-1:0] w_lvl;
   logic [N_CH-1:0] w_det;
   logic [N_CH-1:0] w_pulse_nxt;
   logic [N_CH-1:0] r_prev;
   logic [CW-1:0]   r_cnt     [N_CH];
   logic [CW-1:0]   w_cnt_nxt [N_CH];

   generate
      if (N_CH < 1 || PULSE_W < 1 || DEBOUNCE_CYC < 1) begin : g_param_err
         $error("edge_pulse_gen: N_CH, PULSE_W and DEBOUNCE_CYC must all be >= 1");
      end

      if (SYNC_STAGES > 0) begin : g_sync
         logic [N_CH-1:0] r_sync [SYNC_STAGES];

         // Shift raw levels through the synchroniser chain; reset discards in-flight data
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            end else begin
               r_sync[0] <= level_in;
               for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            end
         end

         assign w_sync = r_sync[SYNC_STAGES-1];
      end else begin : g_nosync
         assign w_sync = level_in;
      end
   endgenerate

`ifdef EDGE_PULSE_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);

   logic [N_CH-1:0] r_lvl;
   logic [DW-1:0]   r_db_cnt [N_CH];

   // Accept a new level only after it has differed from the filtered level for DEBOUNCE_CYC cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lvl <= '0;
         for (int i = 0; i < N_CH; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_sync[i] == r_lvl[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
               r_lvl[i]    <= w_sync[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign w_lvl = r_lvl;
`else
   assign w_lvl = w_sync;
`endif

   // Edge detection against the previous filtered level, gated by the per-channel mode bits
   always_comb begin
      w_det = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_det[i] = (w_lvl[i] & ~r_prev[i] & mode[2*i]) |
                    (~w_lvl[i] & r_prev[i] & mode[2*i+1]);
      end
   end

   // Width counter next state: a detection (re)loads, otherwise count down to zero
   always_comb begin
      w_pulse_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_det[i]) begin
            w_cnt_nxt[i] = CW'(PULSE_W);
         end else if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - CW'(1);
         end
         w_pulse_nxt[i] = (w_cnt_nxt[i] != '0);
      end
   end

   // Register previous level, width counters, pulses, sticky flags and the pulse summary
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev     <= '0;
         pulse_out  <= '0;
         event_flag <= '0;
         any_pulse  <= 1'b0;
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
      end else begin
         r_prev     <= w_lvl;
         pulse_out  <= w_pulse_nxt;
         event_flag <= (event_flag & ~clr) | w_det;
         any_pulse  <= |w_pulse_nxt;
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: one instance with PULSE_W=1 (A) and one with PULSE_W=3 (B).
// Expected values are hand-derived; latency accounts for the optional debounce stage.
module tb_edge_pulse_gen;

`ifdef EDGE_PULSE_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   localparam int LAT = 2 + DB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  lvlA = '0, clrA = '0, lvlB = '0, clrB = '0;
   logic [15:0] modeA = '0, modeB = '0;
   logic [7:0]  pulseA, flagA, pulseB, flagB;
   logic        anyA, anyB;

   int n_err = 0;
   int n_chk = 0;

   edge_pulse_gen #(.N_CH(8), .SYNC_STAGES(2), .PULSE_W(1), .DEBOUNCE_CYC(4)) dut_a (
      .clk(clk), .reset(reset), .level_in(lvlA), .mode(modeA), .clr(clrA),
      .pulse_out(pulseA), .event_flag(flagA), .any_pulse(anyA)
   );

   edge_pulse_gen #(.N_CH(8), .SYNC_STAGES(2), .PULSE_W(3), .DEBOUNCE_CYC(4)) dut_b (
      .clk(clk), .reset(reset), .level_in(lvlB), .mode(modeB), .clr(clrB),
      .pulse_out(pulseB), .event_flag(flagB), .any_pulse(anyB)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_pulseA", pulseA, 8'h00);
      chk("rst_flagA",  flagA,  8'h00);
      chk("rst_anyA",   anyA,   1'b0);
      chk("rst_pulseB", pulseB, 8'h00);
      chk("rst_flagB",  flagB,  8'h00);
      reset = 1'b0;

      // ch0 rise mode: one-cycle pulse at k+LAT
      modeA[1:0] = 2'b01;
      tick();
      lvlA[0] = 1'b1;
      for (int m = 0; m <= LAT + 1; m++) begin
         tick();
         chk("ch0_rise_pulse", pulseA, (m == LAT) ? 8'h01 : 8'h00);
         chk("ch0_rise_any",   anyA,   (m == LAT));
      end
      chk("ch0_rise_flag", flagA, 8'h01);

      // ch0 falling edge in rise mode: no pulse, flag held
      lvlA[0] = 1'b0;
      for (int m = 0; m <= LAT + 2; m++) begin
         tick();
         chk("ch0_fall_nopulse", pulseA, 8'h00);
      end
      chk("ch0_flag_held", flagA, 8'h01);

      // ch3 both-edges: clr coincident with a detection loses to the set
      modeA[7:6] = 2'b11;
      lvlA[3] = 1'b1;
      repeat (LAT + 1) tick();
      chk("ch3_first_flag", flagA[3], 1'b1);
      lvlA[3] = 1'b0;
      repeat (LAT) tick();
      clrA[3] = 1'b1;
      tick();
      chk("ch3_setwins_flag",  flagA[3],  1'b1);
      chk("ch3_setwins_pulse", pulseA[3], 1'b1);
      tick();
      chk("ch3_clr_flag", flagA[3], 1'b0);
      clrA[3] = 1'b0;
      tick();
      chk("ch3_clr_stays", flagA, 8'h01);

`ifndef EDGE_PULSE_DEBOUNCE_EN
      // ch6 both-edges toggling every cycle with PULSE_W=1: continuous high
      modeA[13:12] = 2'b11;
      for (int i = 0; i < 6; i++) begin
         lvlA[6] = ~lvlA[6];
         tick();
         if (i >= 2) chk("ch6_toggle_high", pulseA[6], 1'b1);
      end
      tick();
      chk("ch6_tail1", pulseA[6], 1'b1);
      tick();
      chk("ch6_tail2", pulseA[6], 1'b1);
      tick();
      chk("ch6_end", pulseA, 8'h00);
      chk("ch6_end_any", anyA, 1'b0);

      // B ch1 both-edges, rise then fall 2 cycles apart: 5 continuous high cycles
      modeB[3:2] = 2'b11;
      lvlB[1] = 1'b1;
      for (int m = 0; m <= LAT + 6; m++) begin
         if (m == 2) lvlB[1] = 1'b0;
         tick();
         chk("b_ch1_retrig", pulseB[1], (m >= LAT && m <= LAT + 4));
         chk("b_ch1_any",    anyB,      (m >= LAT && m <= LAT + 4));
      end
`else
      // ch0 debounce: 3-cycle glitch filtered, 6-cycle level accepted
      clrA[0] = 1'b1;
      tick();
      clrA[0] = 1'b0;
      chk("db_flag_cleared", flagA[0], 1'b0);
      lvlA[0] = 1'b1;
      repeat (3) tick();
      lvlA[0] = 1'b0;
      for (int m = 0; m < 12; m++) begin
         tick();
         chk("db_glitch_nopulse", pulseA[0], 1'b0);
      end
      chk("db_glitch_noflag", flagA[0], 1'b0);
      lvlA[0] = 1'b1;
      for (int m = 0; m < 10; m++) begin
         if (m == 6) lvlA[0] = 1'b0;
         tick();
         chk("db_long_pulse", pulseA[0], (m == 6));
      end
      chk("db_long_flag", flagA[0], 1'b1);
`endif

      // B ch2 fall mode, switched off one cycle into the pulse: full 3 cycles
      modeB[5:4] = 2'b10;
      lvlB[2] = 1'b1;
      repeat (LAT + 2) begin
         tick();
         chk("b_ch2_rise_nopulse", pulseB[2], 1'b0);
      end
      lvlB[2] = 1'b0;
      for (int m = 0; m <= LAT; m++) begin
         tick();
         chk("b_ch2_start", pulseB[2], (m == LAT));
      end
      modeB[5:4] = 2'b00;
      tick();
      chk("b_ch2_hold1", pulseB[2], 1'b1);
      tick();
      chk("b_ch2_hold2", pulseB[2], 1'b1);
      tick();
      chk("b_ch2_end", pulseB[2], 1'b0);
      chk("b_ch2_flag", flagB[2], 1'b1);
      clrB[2] = 1'b1;
      tick();
      clrB[2] = 1'b0;
      chk("b_ch2_clr", flagB[2], 1'b0);
      lvlB[2] = 1'b1;
      repeat (LAT + 2) tick();
      lvlB[2] = 1'b0;
      for (int m = 0; m < LAT + 3; m++) begin
         tick();
         chk("b_ch2_off_nopulse", pulseB[2], 1'b0);
      end
      chk("b_ch2_off_noflag", flagB[2], 1'b0);

      // A: all levels high through reset, mixed modes -> rise/both channels pulse once
      modeA = {2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
      reset = 1'b1;
      lvlA  = 8'hFF;
      repeat (3) tick();
      chk("hold_rst_pulse", pulseA, 8'h00);
      chk("hold_rst_flag",  flagA,  8'h00);
      chk("hold_rst_any",   anyA,   1'b0);
      reset = 1'b0;
      for (int m = 0; m <= LAT + 1; m++) begin
         tick();
         chk("hold_rel_pulse", pulseA, (m == LAT) ? 8'hB5 : 8'h00);
         chk("hold_rel_any",   anyA,   (m == LAT));
      end
      chk("hold_rel_flag", flagA, 8'hB5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
